fpu_div_ctrl: RTL and testbench

FPU_DIV_CTRL -- requirements
Module: fpu_div_ctrl

---
 rtl/fpu_div_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fpu_div_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_ctrl.sv
// fpu_div_ctrl: sequencing controller around an external sequential
// single-precision divider. Special operands are resolved locally in one
// cycle; everything else is launched to the divider and guarded by a
// timeout so a hung divider cannot wedge the request channel.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a request; operands captured on handshake
//   CHECK  | classify operands; special cases answered directly
//   LAUNCH | one-cycle div_start pulse, timeout counter cleared
//   WAIT   | waiting for div_done, counting toward TIMEOUT
//   RESP   | response presented until the consumer accepts it
module fpu_div_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic        div_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        busy
);

  localparam int          CNT_W = 16;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        div_a_q, div_a_d;
  logic [31:0]        div_b_q, div_b_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [4:0]         rsp_flags_q, rsp_flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        a_exp_max, b_exp_max;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        special, sign;
  logic [CNT_W-1:0] cnt_inc;
  logic        timeout_hit;

  // Operand classification works on the captured operands, which stay
  // stable from CHECK onward.
  always_comb begin
    a_exp_max   = &div_a_q[30:23];
    b_exp_max   = &div_b_q[30:23];
    a_nan       = a_exp_max & (|div_a_q[22:0]);
    b_nan       = b_exp_max & (|div_b_q[22:0]);
    a_inf       = a_exp_max & ~(|div_a_q[22:0]);
    b_inf       = b_exp_max & ~(|div_b_q[22:0]);
    a_zero      = ~(|div_a_q[30:0]);
    b_zero      = ~(|div_b_q[30:0]);
    special     = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    sign        = div_a_q[31] ^ div_b_q[31];
    cnt_inc     = cnt_q + 1'b1;
    timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; div_done is only honoured in WAIT and wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_CHECK;
      S_CHECK:  state_d = special ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (div_done || timeout_hit) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    div_start = (state_q == S_LAUNCH);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next values: operand capture, special-case answers, completion.
  always_comb begin
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          div_a_d = req_a;
          div_b_d = req_b;
        end
      end
      S_CHECK: begin
        rsp_flags_d = 5'b0_0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          rsp_result_d = QNAN;
          rsp_flags_d  = 5'b1_0000;
        end else if (a_inf) begin
          rsp_result_d = {sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
          rsp_result_d = {sign, 8'hFF, 23'd0};
          rsp_flags_d  = 5'b0_1000;
        end else if (b_inf || a_zero) begin
          rsp_result_d = {sign, 31'd0};
        end
      end
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (div_done) begin
          rsp_result_d = div_result;
          rsp_flags_d  = {2'b00, (&div_result[30:23]), ~(|div_result[30:23]), 1'b0};
        end else if (timeout_hit) begin
          rsp_result_d = QNAN;
          rsp_flags_d  = 5'b0_0001;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a_q      <= '0;
      div_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      cnt_q        <= '0;
    end else begin
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      cnt_q        <= cnt_d;
    end
  end

  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Directed bench for fpu_div_ctrl with a scoreboard queue and a decoupled
// response monitor. A behavioural divider returns a preset result a preset
// number of cycles after div_start (0 = never answers).
module tb_fpu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] div_res = '0;
  logic        div_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        busy;

  fpu_div_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_res), .div_done(div_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider model.
  int div_lat = 0;
  int remain = 0;
  int starts = 0;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (remain > 0) begin
      remain--;
      if (remain == 0) div_done = 1'b1;
    end
    if (div_start) begin
      starts++;
      remain = div_lat;
    end
  end

  // Response monitor: latency at rsp_valid rise, value every valid cycle.
  int hs_cyc = 0;
  int rsp_hs_cyc = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (req_valid && req_ready) hs_cyc = cyc;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid 1 expected no response");
        end else begin
          e = exp_q[0];
          if (!prev_v && e.lat >= 0) chk("latency", 32'(cyc - hs_cyc), 32'(e.lat));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_hs_cyc = cyc;
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_wait_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    tick(1);
  endtask

  typedef struct {
    logic [31:0] a, b, res;
    logic [4:0]  flags;
    int          lat, dlat;
    logic [31:0] dres;
  } vec_t;

  vec_t vecs[14];
  int   exp_starts = 0;

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 26, 32'h40400000};
    vecs[1]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000,  2,  0, 32'h0};
    vecs[2]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000,  2,  0, 32'h0};
    vecs[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000,  2,  0, 32'h0};
    vecs[4]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000,  2,  0, 32'h0};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000,  2,  0, 32'h0};
    vecs[6]  = '{32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000,  2,  0, 32'h0};
    vecs[7]  = '{32'h00000000, 32'hC0400000, 32'h80000000, 5'b00000,  2,  0, 32'h0};
    vecs[8]  = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 5'b10000,  2,  0, 32'h0};
    vecs[9]  = '{32'hBF800000, 32'h80000000, 32'h7F800000, 5'b01000,  2,  0, 32'h0};
    vecs[10] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 5'b00100,  8,  5, 32'h7F800000};
    vecs[11] = '{32'h00800000, 32'h7F000000, 32'h00000000, 5'b00010,  6,  3, 32'h00000000};
    // never answered: 64 WAIT cycles then timeout
    vecs[12] = '{32'h40000000, 32'h3F800000, 32'h7FC00000, 5'b00001, 67,  0, 32'h0};
    // done lands on the cycle the counter reaches TIMEOUT: completion wins
    vecs[13] = '{32'h40000000, 32'h40000000, 32'h3F800000, 5'b00000, 67, 64, 32'h3F800000};

    // reset values
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    tick(1);

    foreach (vecs[i]) begin
      div_lat = vecs[i].dlat;
      div_res = vecs[i].dres;
      if (vecs[i].lat > 2) exp_starts++;
      exp_q.push_back('{vecs[i].res, vecs[i].flags, vecs[i].lat});
      send(vecs[i].a, vecs[i].b);
      drain();
      chk("div_start_count", 32'(starts), 32'(exp_starts));
    end
    chk("div_a_held", div_a, 32'h40000000);
    chk("div_b_held", div_b, 32'h40000000);

    // back-pressure: response held, second request waits
    rsp_ready = 1'b0;
    exp_q.push_back('{32'h7F800000, 5'b01000, 2});
    send(32'h3F800000, 32'h00000000);
    exp_q.push_back('{32'h7FC00000, 5'b10000, 2});
    req_a = 32'h7FC00001;
    req_b = 32'h3F800000;
    req_valid = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("second_accept_gap", 32'(cyc - rsp_hs_cyc), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
    drain();

    // reset in WAIT, late div_done must be ignored
    div_lat = 10;
    div_res = 32'h40000000;
    send(32'h40800000, 32'h40000000);
    exp_starts++;
    tick(6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_div_a", div_a, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_starts", 32'(starts), 32'(exp_starts));

    div_lat = 4;
    div_res = 32'h40A00000;
    exp_starts++;
    exp_q.push_back('{32'h40A00000, 5'b00000, 7});
    send(32'h41200000, 32'h40000000);
    drain();
    chk("final_starts", 32'(starts), 32'(exp_starts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
